// File: rtl/swap_pkg.sv
// ============================================================================
// Module      : swap_pkg
// Description : Shared types and constants for the register-pair swap scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swap_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } swap_state_t;

  // Bank read data arrives one cycle after the address; WR_A relies on this to bypass B's value.
  localparam int RD_LATENCY = 1;
  localparam int STATS_W    = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/swap_rr_arb.sv
// ============================================================================
// Module      : swap_rr_arb
// Description : Round-robin arbiter; search starts one past the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] r_last;
  int              w_cand;
  logic [ID_W-1:0] w_cand_id;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    w_cand    = 0;
    w_cand_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = int'(r_last) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      w_cand_id = ID_W'(w_cand);
      if (!grant_any && req[w_cand_id]) begin
        grant[w_cand_id] = 1'b1;
        grant_id         = w_cand_id;
        grant_any        = 1'b1;
      end
    end
  end

  // Reset to the highest index so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (update && grant_any) begin
      r_last <= grant_id;
    end
  end

endmodule

`default_nettype wire

// File: rtl/swap_scheduler.sv
// ============================================================================
// Module      : swap_scheduler
// Description : Round-robin sequencer of register-pair swaps on a single-port
//               bank (read A, read B, write A, write B). Optional swap counter
//               enabled by defining SWAP_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_scheduler
  import swap_pkg::*;
#(
  parameter int   NUM_REQ  = 2,
  parameter int   NUM_REGS = 8,
  parameter int   DATA_W   = 32,
  parameter int   IDX_W    = $clog2(NUM_REGS),
  localparam int  ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx_a,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic                     done_err,
  output logic [IDX_W-1:0]         rf_addr,
  input  logic [DATA_W-1:0]        rf_rd_data,
  output logic                     rf_wr_en,
  output logic [DATA_W-1:0]        rf_wr_data
`ifdef SWAP_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0]       swap_count
`endif
);

  swap_state_t        r_state;
  swap_state_t        w_next;
  logic [IDX_W-1:0]   r_idx_a;
  logic [IDX_W-1:0]   r_idx_b;
  logic [ID_W-1:0]    r_id;
  logic               r_err;
  logic [DATA_W-1:0]  r_ta;
  logic [DATA_W-1:0]  r_tb;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_grant_any;
  logic               w_idle;
  logic [IDX_W-1:0]   w_sel_a;
  logic [IDX_W-1:0]   w_sel_b;
  logic               w_bad;
  logic               w_same;

  assign w_idle = (r_state == IDLE);

  swap_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .update    (w_idle),
    .grant     (w_grant),
    .grant_id  (w_grant_id),
    .grant_any (w_grant_any)
  );

  assign w_sel_a = req_idx_a[w_grant_id*IDX_W +: IDX_W];
  assign w_sel_b = req_idx_b[w_grant_id*IDX_W +: IDX_W];
  assign w_bad   = (int'(w_sel_a) >= NUM_REGS) || (int'(w_sel_b) >= NUM_REGS);
  assign w_same  = (w_sel_a == w_sel_b);

  // Masked during reset so every output reads 0 while rst is high.
  assign req_ready = (w_idle && !rst) ? w_grant : '0;

  always_comb begin
    w_next     = r_state;
    rf_addr    = '0;
    rf_wr_en   = 1'b0;
    rf_wr_data = '0;
    done_valid = 1'b0;
    done_id    = '0;
    done_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_any) begin
          w_next = (w_bad || w_same) ? DONE : RD_A;
        end
      end
      RD_A: begin
        rf_addr = r_idx_a;
        w_next  = RD_B;
      end
      RD_B: begin
        rf_addr = r_idx_b;
        w_next  = WR_A;
      end
      WR_A: begin
        rf_addr    = r_idx_a;
        rf_wr_en   = 1'b1;
        rf_wr_data = rf_rd_data;
        w_next     = WR_B;
      end
      WR_B: begin
        rf_addr    = r_idx_b;
        rf_wr_en   = 1'b1;
        rf_wr_data = r_ta;
        w_next     = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        done_id    = r_id;
        done_err   = r_err;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx_a <= '0;
      r_idx_b <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_ta    <= '0;
      r_tb    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_idx_a <= w_sel_a;
            r_idx_b <= w_sel_b;
            r_id    <= w_grant_id;
            r_err   <= w_bad;
          end
        end
        RD_B:    r_ta <= rf_rd_data;
        WR_A:    r_tb <= rf_rd_data;
        default: ;
      endcase
    end
  end

`ifdef SWAP_SCHED_STATS_EN
  logic [STATS_W-1:0] r_swap_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap_count <= '0;
    end else if ((r_state == DONE) && !r_err) begin
      r_swap_count <= sat_inc(r_swap_count);
    end
  end

  assign swap_count = r_swap_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_swap_scheduler.sv
// ============================================================================
// Module      : tb_swap_scheduler
// Description : Scoreboard bench for swap_scheduler with a behavioural bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swap_scheduler;

  localparam int NUM_REQ  = 2;
  localparam int NUM_REGS = 6;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*IDX_W-1:0] req_idx_a = '0;
  logic [NUM_REQ*IDX_W-1:0] req_idx_b = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     done_valid;
  logic [0:0]               done_id;
  logic                     done_err;
  logic [IDX_W-1:0]         rf_addr;
  logic [DATA_W-1:0]        rf_rd_data;
  logic                     rf_wr_en;
  logic [DATA_W-1:0]        rf_wr_data;
`ifdef SWAP_SCHED_STATS_EN
  logic [15:0]              swap_count;
`endif

  always #5 clk = ~clk;

  swap_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_idx_a  (req_idx_a),
    .req_idx_b  (req_idx_b),
    .req_ready  (req_ready),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err),
    .rf_addr    (rf_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data)
`ifdef SWAP_SCHED_STATS_EN
    ,
    .swap_count (swap_count)
`endif
  );

  // Behavioural single-port bank, one-cycle read latency.
  logic [DATA_W-1:0] bank [0:7];
  logic              poke_en = 1'b0;
  logic [IDX_W-1:0]  poke_addr = '0;
  logic [DATA_W-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) bank[poke_addr] <= poke_data;
    else if (rf_wr_en) bank[rf_addr] <= rf_wr_data;
    rf_rd_data <= bank[rf_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cyc; logic [IDX_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;
  typedef struct { int cyc; int id; logic err; } done_exp_t;

  wr_exp_t           exp_wr[$];
  done_exp_t         exp_done[$];
  int                grant_hist[$];
  logic [DATA_W-1:0] shadow [0:7];
  int                model_last = NUM_REQ - 1;
  int                busy_until = 0;
  int                wr_seen = 0;
  int                m_win;
  logic [NUM_REQ-1:0] m_exp_ready;
  logic [IDX_W-1:0]  m_a, m_b;
  wr_exp_t           m_w;
  done_exp_t         m_d;

  // Scoreboard: expectations are pushed at each observed handshake, popped at each write/done.
  always @(negedge clk) begin
    if (rst) begin
      exp_wr.delete();
      exp_done.delete();
      model_last = NUM_REQ - 1;
      busy_until = 0;
    end else begin
      if (req_ready != '0) begin
        m_win = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (m_win < 0 && req_valid[(model_last + k) % NUM_REQ]) m_win = (model_last + k) % NUM_REQ;
        m_exp_ready = '0;
        if (m_win >= 0) m_exp_ready[m_win] = 1'b1;
        checks++;
        if (req_ready !== m_exp_ready) begin
          failures++;
          $display("FAIL arb_grant cyc=%0d got=%b exp=%b", cyc, req_ready, m_exp_ready);
        end
        if (m_win < 0) m_win = 0;
        checks++;
        if (cyc < busy_until) begin
          failures++;
          $display("FAIL grant_while_busy cyc=%0d earliest=%0d", cyc, busy_until);
        end
        m_a = req_idx_a[m_win*IDX_W +: IDX_W];
        m_b = req_idx_b[m_win*IDX_W +: IDX_W];
        if (int'(m_a) >= NUM_REGS || int'(m_b) >= NUM_REGS) begin
          exp_done.push_back('{cyc + 1, m_win, 1'b1});
          busy_until = cyc + 2;
        end else if (m_a == m_b) begin
          exp_done.push_back('{cyc + 1, m_win, 1'b0});
          busy_until = cyc + 2;
        end else begin
          exp_wr.push_back('{cyc + 3, m_a, shadow[m_b]});
          exp_wr.push_back('{cyc + 4, m_b, shadow[m_a]});
          exp_done.push_back('{cyc + 5, m_win, 1'b0});
          busy_until = cyc + 6;
        end
        model_last = m_win;
        grant_hist.push_back(m_win);
      end
      if (rf_wr_en) begin
        wr_seen++;
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d", cyc, rf_addr, rf_wr_data);
        end else begin
          m_w = exp_wr.pop_front();
          if (cyc !== m_w.cyc || rf_addr !== m_w.addr || rf_wr_data !== m_w.data) begin
            failures++;
            $display("FAIL write got cyc=%0d addr=%0d data=%0d exp cyc=%0d addr=%0d data=%0d",
                     cyc, rf_addr, rf_wr_data, m_w.cyc, m_w.addr, m_w.data);
          end
          shadow[m_w.addr] = m_w.data;
        end
      end
      if (done_valid) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d id=%0d err=%0b", cyc, done_id, done_err);
        end else begin
          m_d = exp_done.pop_front();
          if (cyc !== m_d.cyc || int'(done_id) !== m_d.id || done_err !== m_d.err) begin
            failures++;
            $display("FAIL done got cyc=%0d id=%0d err=%0b exp cyc=%0d id=%0d err=%0b",
                     cyc, done_id, done_err, m_d.cyc, m_d.id, m_d.err);
          end
        end
        checks++;
        if (exp_wr.size() != 0) begin
          failures++;
          $display("FAIL missing_write cyc=%0d pending=%0d", cyc, exp_wr.size());
        end
        exp_wr.delete();
      end
    end
  end

  task automatic poke(input int addr, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    poke_en   = 1'b1;
    poke_addr = IDX_W'(addr);
    poke_data = d;
    shadow[addr] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive_req(input int id, input int a, input int b);
    req_idx_a[id*IDX_W +: IDX_W] = IDX_W'(a);
    req_idx_b[id*IDX_W +: IDX_W] = IDX_W'(b);
    req_valid[id] = 1'b1;
  endtask

  // Holds the request until accepted, then releases it.
  task automatic issue(input int id, input int a, input int b);
    bit got = 1'b0;
    @(posedge clk); #1;
    drive_req(id, a, b);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (req_ready[id]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ready_timeout req=%0d", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && exp_done.size() != 0; n++) begin
      @(negedge clk); #2;
    end
    checks++;
    if (exp_done.size() != 0) begin
      failures++;
      $display("FAIL done_timeout pending=%0d", exp_done.size());
      exp_done.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) poke(i, DATA_W'(i * 11 + 1));
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      failures++;
      $display("FAIL ready_in_reset got=%b exp=00", req_ready);
    end
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, done_valid, done_id, done_err, rf_addr, rf_wr_en, rf_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b dv=%b id=%0d err=%b addr=%0d we=%b wd=%0d",
               req_ready, done_valid, done_id, done_err, rf_addr, rf_wr_en, rf_wr_data);
    end
`ifdef SWAP_SCHED_STATS_EN
    checks++;
    if (swap_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", swap_count);
    end
`endif
  endtask

  task automatic test_rr_alternate();
    int start = grant_hist.size();
    @(posedge clk); #1;
    drive_req(0, 0, 1);
    drive_req(1, 2, 4);
    for (int n = 0; n < 100 && grant_hist.size() < start + 4; n++) begin
      @(negedge clk); #2;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();
    checks++;
    if (grant_hist.size() < start + 4) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=4", grant_hist.size() - start);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_hist[start + k] !== (k % 2)) begin
          failures++;
          $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, grant_hist[start + k], k % 2);
        end
      end
    end
  endtask

  task automatic test_basic_swap();
    poke(3, 32'd30);
    poke(5, 32'd20);
    issue(0, 3, 5);
    wait_drain();
    checks++;
    if (bank[3] !== 32'd20 || bank[5] !== 32'd30) begin
      failures++;
      $display("FAIL basic_bank got [3]=%0d [5]=%0d exp [3]=20 [5]=30", bank[3], bank[5]);
    end
  endtask

  task automatic test_degenerate();
    int ws = wr_seen;
    logic [DATA_W-1:0] v4 = bank[4];
    issue(1, 4, 4);
    wait_drain();
    checks++;
    if (wr_seen !== ws || bank[4] !== v4) begin
      failures++;
      $display("FAIL degenerate_writes got=%0d exp=0 bank4=%0d exp=%0d", wr_seen - ws, bank[4], v4);
    end
  endtask

  task automatic test_error();
    int ws = wr_seen;
    logic [DATA_W-1:0] v2 = bank[2];
    issue(0, 2, 7);
    wait_drain();
    checks++;
    if (wr_seen !== ws || bank[2] !== v2) begin
      failures++;
      $display("FAIL error_bank writes=%0d exp=0 bank2=%0d exp=%0d", wr_seen - ws, bank[2], v2);
    end
  endtask

  task automatic test_reset_mid_op();
    bit got = 1'b0;
    poke(3, 32'd30);
    poke(5, 32'd20);
    @(posedge clk); #1;
    drive_req(0, 3, 5);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (req_ready[0]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ready_timeout req=0 (reset test)");
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, done_valid, done_id, done_err, rf_addr, rf_wr_en, rf_wr_data} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs dv=%b addr=%0d we=%b wd=%0d", done_valid, rf_addr, rf_wr_en, rf_wr_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bank[3] !== 32'd20 || bank[5] !== 32'd20) begin
      failures++;
      $display("FAIL half_swap got [3]=%0d [5]=%0d exp [3]=20 [5]=20", bank[3], bank[5]);
    end
    issue(1, 3, 5);
    wait_drain();
    checks++;
    if (bank[3] !== 32'd20 || bank[5] !== 32'd20 || bank[3] !== shadow[3]) begin
      failures++;
      $display("FAIL post_reset_swap got [3]=%0d [5]=%0d exp 20 20", bank[3], bank[5]);
    end
  endtask

`ifdef SWAP_SCHED_STATS_EN
  task automatic test_stats();
    logic [15:0] c0 = swap_count;
    issue(0, 1, 2);
    wait_drain();
    issue(1, 0, 0);
    wait_drain();
    issue(0, 3, 7);
    wait_drain();
    issue(1, 4, 5);
    wait_drain();
    checks++;
    if (swap_count !== c0 + 16'd3) begin
      failures++;
      $display("FAIL stats_count got=%0d exp=%0d", swap_count, c0 + 16'd3);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_alternate();
    test_basic_swap();
    test_degenerate();
    test_error();
    test_reset_mid_op();
`ifdef SWAP_SCHED_STATS_EN
    test_stats();
`endif
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
